// File: rtl/ahb_spi_master.sv
// AHB-Lite slave wrapping a mode-0 SPI master: CTRL/STATUS, slave-select,
// TX and RX registers, and a 1..4-byte shift engine clocked by a divided HCLK.
module ahb_spi_master #(
    parameter int CLK_DIV = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        SPI_MISO_i,
    output logic        SPI_MOSI_o,
    output logic [31:0] SPI_SS_o,
    output logic        SPI_CLK_o
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] HALF_M1 = DW'(CLK_DIV / 2 - 1);
    localparam logic [DW-1:0] FULL_M1 = DW'(CLK_DIV - 1);

    logic          sel_q, sel_d;
    logic          wr_q, wr_d;
    logic [1:0]    addr_q, addr_d;
    logic [31:0]   ctrl_q, ctrl_d;
    logic [31:0]   ssreg_q, ssreg_d;
    logic [31:0]   txdata_q, txdata_d;
    logic [31:0]   rxdata_q, rxdata_d;
    logic [31:0]   tx_shift_q, tx_shift_d;
    logic [31:0]   rx_shift_q, rx_shift_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [4:0]    nbits_m1_q, nbits_m1_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          busy_q, busy_d;
    logic          tx_done_q, tx_done_d;
    logic          rx_full_q, rx_full_d;
    logic          spi_clk_q, spi_clk_d;

    logic [3:0]    nbytes_raw;
    logic [2:0]    nbytes_eff;
    logic [5:0]    nbits_m1_full;
    logic          sspol;
    logic          start;
    logic          unused_bits;

    assign nbytes_raw    = ctrl_q[15:12];
    assign sspol         = ctrl_q[6];
    assign nbytes_eff    = (nbytes_raw == 4'd0 || nbytes_raw > 4'd4) ? 3'd4 : nbytes_raw[2:0];
    assign nbits_m1_full = {nbytes_eff, 3'b000} - 6'd1;

    assign HREADYOUT  = 1'b1;
    assign SPI_SS_o   = sspol ? ssreg_q : ~ssreg_q;
    assign SPI_CLK_o  = spi_clk_q;
    assign SPI_MOSI_o = busy_q & tx_shift_q[31];

    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HSIZE, HTRANS[0], ctrl_q, nbits_m1_full[5]};

    // Read mux: data is presented during the data phase of a selected read
    always_comb begin
        HRDATA = 32'd0;
        if (sel_q && !wr_q) begin
            case (addr_q)
                2'd0: HRDATA = {16'd0, nbytes_raw, 5'd0, sspol, 1'b0, tx_done_q, 2'b00, busy_q, rx_full_q};
                2'd1: HRDATA = ssreg_q;
                2'd2: HRDATA = txdata_q;
                default: HRDATA = rxdata_q;
            endcase
        end
    end

    // Next-state logic: address-phase capture, register writes, flag clears, then the shift engine
    always_comb begin
        sel_d      = HSEL & HTRANS[1] & HREADY;
        wr_d       = HWRITE;
        addr_d     = HADDR[3:2];
        ctrl_d     = ctrl_q;
        ssreg_d    = ssreg_q;
        txdata_d   = txdata_q;
        rxdata_d   = rxdata_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        nbits_m1_d = nbits_m1_q;
        div_cnt_d  = div_cnt_q;
        busy_d     = busy_q;
        tx_done_d  = tx_done_q;
        rx_full_d  = rx_full_q;
        spi_clk_d  = spi_clk_q;
        start      = 1'b0;

        if (sel_q && !wr_q && addr_q == 2'd3) begin
            rx_full_d = 1'b0;
            tx_done_d = 1'b0;
        end

        if (sel_q && wr_q) begin
            case (addr_q)
                2'd0: ctrl_d  = HWDATA;
                2'd1: ssreg_d = HWDATA;
                2'd2: begin
                    if (!busy_q) begin
                        txdata_d = HWDATA;
                        start    = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (start) begin
            busy_d     = 1'b1;
            tx_done_d  = 1'b0;
            div_cnt_d  = '0;
            bit_cnt_d  = 5'd0;
            spi_clk_d  = 1'b0;
            nbits_m1_d = nbits_m1_full[4:0];
            case (nbytes_eff)
                3'd1:    tx_shift_d = {HWDATA[7:0], 24'd0};
                3'd2:    tx_shift_d = {HWDATA[15:0], 16'd0};
                3'd3:    tx_shift_d = {HWDATA[23:0], 8'd0};
                default: tx_shift_d = HWDATA;
            endcase
        end else if (busy_q) begin
            div_cnt_d = div_cnt_q + 1'b1;
            if (div_cnt_q == HALF_M1) begin
                spi_clk_d  = 1'b1;
                rx_shift_d = {rx_shift_q[30:0], SPI_MISO_i};
                if (bit_cnt_q[2:0] == 3'd7) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        rxdata_d  = rx_shift_d;
                        rx_full_d = 1'b1;
                    end
                end
            end
            if (div_cnt_q == FULL_M1) begin
                spi_clk_d  = 1'b0;
                div_cnt_d  = '0;
                tx_shift_d = {tx_shift_q[30:0], 1'b0};
                bit_cnt_d  = bit_cnt_q + 5'd1;
                if (bit_cnt_q == nbits_m1_q) begin
                    busy_d    = 1'b0;
                    tx_done_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 2'd0;
            ctrl_q     <= 32'd0;
            ssreg_q    <= 32'd0;
            txdata_q   <= 32'd0;
            rxdata_q   <= 32'd0;
            tx_shift_q <= 32'd0;
            rx_shift_q <= 32'd0;
            byte_cnt_q <= 2'd0;
            bit_cnt_q  <= 5'd0;
            nbits_m1_q <= 5'd0;
            div_cnt_q  <= '0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_full_q  <= 1'b0;
            spi_clk_q  <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            ctrl_q     <= ctrl_d;
            ssreg_q    <= ssreg_d;
            txdata_q   <= txdata_d;
            rxdata_q   <= rxdata_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            nbits_m1_q <= nbits_m1_d;
            div_cnt_q  <= div_cnt_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
            rx_full_q  <= rx_full_d;
            spi_clk_q  <= spi_clk_d;
        end
    end

endmodule

// File: tb/tb_ahb_spi_master.sv
// Directed bench for ahb_spi_master: register table plus hand-written transfer sequences.
module tb_ahb_spi_master;

    localparam int CLK_DIV = 8;
    localparam int TCLK    = 10;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        SPI_MISO_i;
    logic        SPI_MOSI_o;
    logic [31:0] SPI_SS_o;
    logic        SPI_CLK_o;

    int          n_vec = 0;
    int          n_err = 0;

    int          pulse_cnt = 0;
    logic [31:0] mosi_cap = 32'd0;
    logic [31:0] miso_word = 32'h01020304;
    int          miso_idx = 31;
    bit          first_rise = 1'b1;
    time         last_rise = 0;
    int          bad_period = 0;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [31:0] exp_ss;
        string       name;
    } vec_t;

    vec_t vecs[8];

    ahb_spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .SPI_MISO_i(SPI_MISO_i),
        .SPI_MOSI_o(SPI_MOSI_o),
        .SPI_SS_o  (SPI_SS_o),
        .SPI_CLK_o (SPI_CLK_o)
    );

    // Free-running bus clock
    always #(TCLK / 2) HCLK = ~HCLK;

    // SPI slave model: supplies the next MISO bit after each rising SPI clock
    assign SPI_MISO_i = miso_word[miso_idx[4:0]];

    // Capture MOSI and check the serial clock period on each rising edge
    initial forever begin
        @(posedge SPI_CLK_o);
        mosi_cap = {mosi_cap[30:0], SPI_MOSI_o};
        pulse_cnt++;
        if (!first_rise && ($time - last_rise) != CLK_DIV * TCLK) bad_period++;
        first_rise = 1'b0;
        last_rise  = $time;
        miso_idx--;
    end

    // Check the serial clock high time on each falling edge
    initial forever begin
        @(negedge SPI_CLK_o);
        if (($time - last_rise) != CLK_DIV * TCLK / 2) bad_period++;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0; HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'd0;
        #2;
        data = HRDATA;
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic [31:0] rd;
        if (v.rd) begin
            ahb_read(v.addr, rd);
            check_output(v.name, rd, v.exp_rd);
        end else begin
            ahb_write(v.addr, v.data);
        end
        check_output({v.name, "_ss"}, SPI_SS_o, v.exp_ss);
    endtask

    task automatic start_monitor();
        pulse_cnt  = 0;
        mosi_cap   = 32'd0;
        first_rise = 1'b1;
        bad_period = 0;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        s = 32'h2;
        for (int t = 0; t < 300 && s[1]; t++) ahb_read(32'h0, s);
        check_output({name, "_idle"}, {31'd0, s[1]}, 32'd0);
    endtask

    task automatic check_xfer(input string name, input int exp_pulses, input logic [31:0] exp_mosi,
                              input logic [31:0] exp_status);
        logic [31:0] s;
        check_output({name, "_pulses"}, pulse_cnt, exp_pulses);
        check_output({name, "_mosi"}, mosi_cap, exp_mosi);
        check_output({name, "_period"}, bad_period, 32'd0);
        check_output({name, "_clk_idle"}, {31'd0, SPI_CLK_o}, 32'd0);
        check_output({name, "_mosi_idle"}, {31'd0, SPI_MOSI_o}, 32'd0);
        ahb_read(32'h0, s);
        check_output({name, "_status"}, s, exp_status);
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0,         32'h0000_0000, 32'hFFFF_FFFF, "status_rst"};
        vecs[1] = '{1'b1, 32'h0000_0008, 32'h0,         32'h0000_0000, 32'hFFFF_FFFF, "txdata_rst"};
        vecs[2] = '{1'b1, 32'h0000_000C, 32'h0,         32'h0000_0000, 32'hFFFF_FFFF, "rxdata_rst"};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_2040, 32'h0,         32'h0000_0000, "wr_ctrl"};
        vecs[4] = '{1'b0, 32'h0000_0004, 32'h0000_0001, 32'h0,         32'h0000_0001, "wr_ssreg"};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'h0,         32'h0000_2040, 32'h0000_0001, "status_cfg"};
        vecs[6] = '{1'b1, 32'h0000_0004, 32'h0,         32'h0000_0001, 32'h0000_0001, "ssreg_rd"};
        vecs[7] = '{1'b1, 32'hABC0_0014, 32'h0,         32'h0000_0001, 32'h0000_0001, "ssreg_alias"};

        HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HADDR = 32'd0; HWRITE = 1'b0;
        HSIZE = 3'b010; HTRANS = 2'b00; HWDATA = 32'd0;
        repeat (3) @(posedge HCLK);
        #1;
        check_output("rst_clk", {31'd0, SPI_CLK_o}, 32'd0);
        check_output("rst_mosi", {31'd0, SPI_MOSI_o}, 32'd0);
        check_output("rst_ss", SPI_SS_o, 32'hFFFF_FFFF);
        check_output("rst_hrdata", HRDATA, 32'd0);
        check_output("hreadyout", {31'd0, HREADYOUT}, 32'd1);
        HRESET = 1'b0;

        for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

        // Two-byte transfer with an ignored TXDATA write while busy
        start_monitor();
        ahb_write(32'h8, 32'h0000_1108);
        ahb_read(32'h0, rd);
        check_output("busy_status", rd, 32'h0000_2042);
        ahb_write(32'h8, 32'h0000_FFFF);
        wait_idle("x1");
        check_xfer("x1", 16, 32'h0000_1108, 32'h0000_2050);

        // Second two-byte transfer completes the 4-byte receive word
        start_monitor();
        ahb_write(32'h8, 32'h0000_ABCD);
        wait_idle("x2");
        check_xfer("x2", 16, 32'h0000_ABCD, 32'h0000_2051);
        ahb_read(32'hC, rd);
        check_output("x2_rxdata", rd, 32'h0102_0304);
        ahb_read(32'h0, rd);
        check_output("x2_status_clr", rd, 32'h0000_2040);

        // Active-low selects and a default 4-byte transfer
        ahb_write(32'h0, 32'h0000_0000);
        ahb_write(32'h4, 32'h0000_0001);
        check_output("ss_low", SPI_SS_o, 32'hFFFF_FFFE);
        start_monitor();
        ahb_write(32'h8, 32'h89AB_CDEF);
        wait_idle("x3");
        check_xfer("x3", 32, 32'h89AB_CDEF, 32'h0000_0011);
        ahb_read(32'h8, rd);
        check_output("x3_txdata", rd, 32'h89AB_CDEF);
        ahb_read(32'hC, rd);
        check_output("x3_rxdata", rd, 32'h0102_0304);

        // Single-byte transfer sends only the low byte
        ahb_write(32'h0, 32'h0000_1000);
        start_monitor();
        ahb_write(32'h8, 32'h1234_56A5);
        wait_idle("x4");
        check_xfer("x4", 8, 32'h0000_00A5, 32'h0000_1010);

        // Reset in the middle of a transfer, then a clean transfer afterwards
        start_monitor();
        ahb_write(32'h8, 32'h0000_00FF);
        repeat (20) @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        #2;
        check_output("abort_clk", {31'd0, SPI_CLK_o}, 32'd0);
        check_output("abort_mosi", {31'd0, SPI_MOSI_o}, 32'd0);
        check_output("abort_ss", SPI_SS_o, 32'hFFFF_FFFF);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        ahb_read(32'h0, rd);
        check_output("abort_status", rd, 32'h0000_0000);
        ahb_write(32'h0, 32'h0000_1000);
        start_monitor();
        ahb_write(32'h8, 32'h0000_003C);
        wait_idle("x5");
        check_xfer("x5", 8, 32'h0000_003C, 32'h0000_1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
